mono_hit_assembler: RTL and testbench
=====================================

# mono_hit_assembler

Consumes the 32-bit word stream from a Monopix readout core's output FIFO and rebuilds one complete hit record from each 3-word group. Each record holds column, row, LE, TE, noise and mute flags, and the 48-bit token timestamp. The block sits on BUS_CLK between the RX core FIFO and downstream hit processing (histogrammer / event builder). It checks word identifier and sequence, drops malformed groups and counts errors.

## Interface
- IDENTIFIER, 4'b0000, expected value of IN_DATA[31:28]
- ERR_CNT_WIDTH, 16, width of the saturating error counters
- BUS_CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- ENABLE  in  1  allow popping input words
- IN_DATA  in  32  head word of the upstream FIFO (first-word fall-through, valid when !IN_EMPTY)
- IN_EMPTY  in  1  upstream FIFO empty
- IN_READ  out  1  pop strobe; head word is consumed in any cycle with IN_READ=1
- HIT_VALID  out  1  record valid
- HIT_READY  in  1  downstream accepts
- HIT_COL  out  6  column
- HIT_ROW  out  9  row
- HIT_LE  out  6  leading edge (binary)
- HIT_TE  out  6  trailing edge (binary)
- HIT_TOT  out  6  TE−LE mod 64 (see Configuration)
- HIT_NOISE  out  1  possible-noise flag
- HIT_MUTE  out  1  mute/inj-high flag
- HIT_TS  out  48  token timestamp
- SEQ_ERR_CNT  out  ERR_CNT_WIDTH  sequence errors, saturating
- ID_ERR_CNT  out  ERR_CNT_WIDTH  identifier mismatches, saturating

## Operation
- Group order on the input is fixed: D, M, H.
  - D: bit27=0; bits[26:0] = {col, le, te, row}.
  - M: [27:25]=100; bits[24:0] = rec[51:27].
  - H: [27:25]=101; bits[24:0] = rec[76:52].
- rec[27] = noise, rec[28] = mute, rec[76:29] = timestamp.
- IN_READ = ENABLE & !IN_EMPTY & state≠OUT.
- States:
  - WAIT_D: D → latch, go to WAIT_M. M/H/other → SEQ_ERR++, stay.
  - WAIT_M: M → latch, go to WAIT_H. D → overwrite D latch, SEQ_ERR++, stay. Other → SEQ_ERR++, go to WAIT_D.
  - WAIT_H: H → latch, go to OUT. D → restart with it, SEQ_ERR++, go to WAIT_M. Other → SEQ_ERR++, go to WAIT_D.
  - OUT: HIT_VALID=1 and fields stable. On HIT_VALID&HIT_READY go to WAIT_D.
- Any word with [31:28]≠IDENTIFIER: popped, discarded, ID_ERR++, state unchanged. The sequence check is skipped for that word.
- Prefix 11x counts as "other".
- Counters saturate at all-ones and do not wrap.
- ENABLE low stops pops only. A pending OUT record still completes its handshake. Partial groups are held.

## Timing
- Reset: state WAIT_D, IN_READ=0, HIT_VALID=0, all HIT_* fields 0, both counters 0. A partial group is discarded.
- Latency: H popped at cycle n → HIT_VALID=1 at n+1.
- Throughput: at most one record per 4 cycles (3 pops plus 1 OUT cycle).
- No pop occurs in OUT, including the handshake cycle. The first pop of the next group is one cycle after the handshake.
- Counter increments are registered and visible the cycle after the offending pop.
- Simultaneous ID error and saturation: the counter holds.

## Configuration
- MONO_TOT_CALC_EN defined: HIT_TOT = (HIT_TE − HIT_LE) mod 64. It is registered together with the other fields, so latency is unchanged.
- MONO_TOT_CALC_EN undefined: HIT_TOT is tied to 0 and no subtractor is built. All other behaviour is identical.

## Structure
- Package mono_hit_pkg holds:
  - state enum
  - prefix constants (PFX_M=3'b100, PFX_H=3'b101)
  - field widths (COL 6, ROW 9, EDGE 6, TS 48)
  - packed hit-record struct
- One sub-module, mono_sat_cnt (parameterised width, synchronous clear, increment, saturate). It is instantiated twice.

## Test plan
- Clean group, col=5 le=10 te=20 row=100, mute=1 noise=0, ts=0x0000_0000_1234:
  - D word 0x00A52864, then M and H with matching IDs.
  - Required: one record with these exact fields; HIT_VALID the cycle after the H pop; counters 0.
- Backpressure: HIT_READY held low 10 cycles with 2 groups queued.
  - Required: fields stable; IN_READ=0 throughout; second record follows after the handshake.
- Sequence faults:
  - Stream D,D,M,H → 1 record built from the second D; SEQ_ERR=1.
  - Stream M,H → no record; SEQ_ERR=2.
- ID fault: one D with ID 4'hF inside a valid group → ID_ERR=1; the record is still produced from the correct words.
- Saturation with ERR_CNT_WIDTH=2: 5 stray M words → SEQ_ERR_CNT=3.
- With MONO_TOT_CALC_EN: le=60, te=4 → HIT_TOT=8. Without it → HIT_TOT=0.
- RST after D,M (before H), then a full group → only the second group is output.

Source files
------------

// File: rtl/mono_hit_pkg.sv
// ============================================================================
// Module   : mono_hit_pkg
// Purpose  : Shared types and constants for the Monopix hit assembler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mono_hit_pkg;

    localparam int COL_W  = 6;
    localparam int ROW_W  = 9;
    localparam int EDGE_W = 6;
    localparam int TS_W   = 48;

    localparam int D_W    = COL_W + 2 * EDGE_W + ROW_W;
    localparam int MH_W   = 25;

    localparam logic [2:0] PFX_M = 3'b100;
    localparam logic [2:0] PFX_H = 3'b101;

    typedef enum logic [1:0] {
        ST_WAIT_D = 2'd0,
        ST_WAIT_M = 2'd1,
        ST_WAIT_H = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    // Field order mirrors the concatenation {H[24:0], M[24:0], D[26:0]}
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic              mute;
        logic              noise;
        logic [COL_W-1:0]  col;
        logic [EDGE_W-1:0] le;
        logic [EDGE_W-1:0] te;
        logic [ROW_W-1:0]  row;
    } hit_rec_t;

endpackage

`default_nettype wire

// File: rtl/mono_sat_cnt.sv
// ============================================================================
// Module   : mono_sat_cnt
// Purpose  : Saturating up-counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mono_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             BUS_CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mono_hit_assembler.sv
// ============================================================================
// Module   : mono_hit_assembler
// Purpose  : Rebuilds hit records from D/M/H word groups of a Monopix FIFO.
//            Optional macro MONO_TOT_CALC_EN enables the registered TE-LE field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mono_hit_assembler
    import mono_hit_pkg::*;
#(
    parameter logic [3:0] IDENTIFIER    = 4'b0000,
    parameter int         ERR_CNT_WIDTH = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     RST,
    input  logic                     ENABLE,
    input  logic [31:0]              IN_DATA,
    input  logic                     IN_EMPTY,
    output logic                     IN_READ,
    output logic                     HIT_VALID,
    input  logic                     HIT_READY,
    output logic [COL_W-1:0]         HIT_COL,
    output logic [ROW_W-1:0]         HIT_ROW,
    output logic [EDGE_W-1:0]        HIT_LE,
    output logic [EDGE_W-1:0]        HIT_TE,
    output logic [EDGE_W-1:0]        HIT_TOT,
    output logic                     HIT_NOISE,
    output logic                     HIT_MUTE,
    output logic [TS_W-1:0]          HIT_TS,
    output logic [ERR_CNT_WIDTH-1:0] SEQ_ERR_CNT,
    output logic [ERR_CNT_WIDTH-1:0] ID_ERR_CNT
);

    state_t          state;
    state_t          state_nxt;
    logic            pop;
    logic            id_ok;
    logic            word_ok;
    logic            is_d;
    logic            is_m;
    logic            is_h;
    logic            load_d;
    logic            load_m;
    logic            load_h;
    logic            seq_inc;
    logic            id_inc;
    logic [D_W-1:0]  d_lat;
    logic [MH_W-1:0] m_lat;
    hit_rec_t        rec_nxt;
    hit_rec_t        hit_q;

    // Popping is frozen in reset and while a record waits for its handshake
    assign pop     = ENABLE & ~IN_EMPTY & (state != ST_OUT) & ~RST;
    assign IN_READ = pop;

    assign id_ok   = (IN_DATA[31:28] == IDENTIFIER);
    assign word_ok = pop & id_ok;
    assign id_inc  = pop & ~id_ok;
    assign is_d    = ~IN_DATA[27];
    assign is_m    = (IN_DATA[27:25] == PFX_M);
    assign is_h    = (IN_DATA[27:25] == PFX_H);

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state <= ST_WAIT_D;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_d    = 1'b0;
        load_m    = 1'b0;
        load_h    = 1'b0;
        seq_inc   = 1'b0;
        case (state)
            ST_WAIT_D: begin
                if (word_ok) begin
                    if (is_d) begin
                        load_d    = 1'b1;
                        state_nxt = ST_WAIT_M;
                    end else begin
                        seq_inc   = 1'b1;
                    end
                end
            end
            ST_WAIT_M: begin
                if (word_ok) begin
                    if (is_m) begin
                        load_m    = 1'b1;
                        state_nxt = ST_WAIT_H;
                    end else if (is_d) begin
                        load_d    = 1'b1;
                        seq_inc   = 1'b1;
                    end else begin
                        seq_inc   = 1'b1;
                        state_nxt = ST_WAIT_D;
                    end
                end
            end
            ST_WAIT_H: begin
                if (word_ok) begin
                    if (is_h) begin
                        load_h    = 1'b1;
                        state_nxt = ST_OUT;
                    end else if (is_d) begin
                        load_d    = 1'b1;
                        seq_inc   = 1'b1;
                        state_nxt = ST_WAIT_M;
                    end else begin
                        seq_inc   = 1'b1;
                        state_nxt = ST_WAIT_D;
                    end
                end
            end
            ST_OUT: begin
                if (HIT_READY) begin
                    state_nxt = ST_WAIT_D;
                end
            end
            default: state_nxt = ST_WAIT_D;
        endcase
    end

    assign rec_nxt = {IN_DATA[MH_W-1:0], m_lat, d_lat};

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            d_lat <= '0;
            m_lat <= '0;
            hit_q <= '0;
        end else begin
            if (load_d) d_lat <= IN_DATA[D_W-1:0];
            if (load_m) m_lat <= IN_DATA[MH_W-1:0];
            if (load_h) hit_q <= rec_nxt;
        end
    end

    assign HIT_VALID = (state == ST_OUT);
    assign HIT_COL   = hit_q.col;
    assign HIT_ROW   = hit_q.row;
    assign HIT_LE    = hit_q.le;
    assign HIT_TE    = hit_q.te;
    assign HIT_NOISE = hit_q.noise;
    assign HIT_MUTE  = hit_q.mute;
    assign HIT_TS    = hit_q.ts;

`ifdef MONO_TOT_CALC_EN
    logic [EDGE_W-1:0] tot_q;

    // Loaded alongside the record so the result carries no extra latency
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            tot_q <= '0;
        end else if (load_h) begin
            tot_q <= rec_nxt.te - rec_nxt.le;
        end
    end

    assign HIT_TOT = tot_q;
`else
    assign HIT_TOT = '0;
`endif

    mono_sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_seq_cnt (
        .BUS_CLK (BUS_CLK),
        .RST     (RST),
        .inc     (seq_inc),
        .count   (SEQ_ERR_CNT)
    );

    mono_sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_id_cnt (
        .BUS_CLK (BUS_CLK),
        .RST     (RST),
        .inc     (id_inc),
        .count   (ID_ERR_CNT)
    );

endmodule

`default_nettype wire

// File: tb/tb_mono_hit_assembler.sv
// ============================================================================
// Module   : tb_mono_hit_assembler
// Purpose  : Self-checking bench for mono_hit_assembler (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mono_hit_assembler;

    localparam int         CW  = 2;
    localparam logic [3:0] ID  = 4'h0;
    localparam int         MAXC = (1 << CW) - 1;

    logic          BUS_CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic [31:0]   IN_DATA;
    logic          IN_EMPTY;
    logic          IN_READ;
    logic          HIT_VALID;
    logic          HIT_READY;
    logic [5:0]    HIT_COL;
    logic [8:0]    HIT_ROW;
    logic [5:0]    HIT_LE;
    logic [5:0]    HIT_TE;
    logic [5:0]    HIT_TOT;
    logic          HIT_NOISE;
    logic          HIT_MUTE;
    logic [47:0]   HIT_TS;
    logic [CW-1:0] SEQ_ERR_CNT;
    logic [CW-1:0] ID_ERR_CNT;

    always #5 BUS_CLK = ~BUS_CLK;

    mono_hit_assembler #(.IDENTIFIER(ID), .ERR_CNT_WIDTH(CW)) dut (
        .BUS_CLK     (BUS_CLK),
        .RST         (RST),
        .ENABLE      (ENABLE),
        .IN_DATA     (IN_DATA),
        .IN_EMPTY    (IN_EMPTY),
        .IN_READ     (IN_READ),
        .HIT_VALID   (HIT_VALID),
        .HIT_READY   (HIT_READY),
        .HIT_COL     (HIT_COL),
        .HIT_ROW     (HIT_ROW),
        .HIT_LE      (HIT_LE),
        .HIT_TE      (HIT_TE),
        .HIT_TOT     (HIT_TOT),
        .HIT_NOISE   (HIT_NOISE),
        .HIT_MUTE    (HIT_MUTE),
        .HIT_TS      (HIT_TS),
        .SEQ_ERR_CNT (SEQ_ERR_CNT),
        .ID_ERR_CNT  (ID_ERR_CNT)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fifo[$];
    logic [31:0] pend[$];
    logic [76:0] exp_q[$];
    int          m_seq = 0;
    int          m_id  = 0;
    int          n_out = 0;
    bit          want_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [31:0] mk_d(input int col, input int le, input int te, input int row);
        logic [31:0] w;
        w = {ID, 1'b0, col[5:0], le[5:0], te[5:0], row[8:0]};
        return w;
    endfunction

    function automatic logic [31:0] mk_m(input logic [47:0] ts, input bit mute, input bit noise);
        logic [31:0] w;
        w = {ID, 3'b100, ts[22:0], mute, noise};
        return w;
    endfunction

    function automatic logic [31:0] mk_h(input logic [47:0] ts);
        logic [31:0] w;
        w = {ID, 3'b101, ts[47:23]};
        return w;
    endfunction

    // Reference: a pending-group list; a record is emitted when D,M,H line up
    task automatic model_pop(input logic [31:0] w, output bit done);
        done = 1'b0;
        if (w[31:28] != ID) begin
            m_id++;
        end else if (!w[27]) begin
            if (pend.size() > 0) m_seq++;
            pend.delete();
            pend.push_back(w);
        end else if (w[27:25] == 3'b100 && pend.size() == 1) begin
            pend.push_back(w);
        end else if (w[27:25] == 3'b101 && pend.size() == 2) begin
            exp_q.push_back({w[24:0], pend[1][24:0], pend[0][26:0]});
            pend.delete();
            done = 1'b1;
        end else begin
            m_seq++;
            pend.delete();
        end
    endtask

    task automatic check_rec(input logic [76:0] r);
        logic [5:0] tot;
`ifdef MONO_TOT_CALC_EN
        tot = r[14:9] - r[20:15];
`else
        tot = 6'd0;
`endif
        chk("rec_col",   HIT_COL,   r[26:21]);
        chk("rec_le",    HIT_LE,    r[20:15]);
        chk("rec_te",    HIT_TE,    r[14:9]);
        chk("rec_row",   HIT_ROW,   r[8:0]);
        chk("rec_noise", HIT_NOISE, r[27]);
        chk("rec_mute",  HIT_MUTE,  r[28]);
        chk("rec_ts",    HIT_TS,    r[76:29]);
        chk("rec_tot",   HIT_TOT,   tot);
    endtask

    task automatic drive_in();
        IN_EMPTY = (fifo.size() == 0);
        IN_DATA  = IN_EMPTY ? $urandom : fifo[0];
    endtask

    task automatic tick();
        bit pop, acc, done;
        @(negedge BUS_CLK);
        if (RST) begin
            chk("in_read_rst", IN_READ, 1'b0);
        end else begin
            chk("seq_cnt", SEQ_ERR_CNT, sat(m_seq));
            chk("id_cnt",  ID_ERR_CNT,  sat(m_id));
            chk("in_read", IN_READ, ENABLE && fifo.size() > 0 && !HIT_VALID);
            if (want_valid) chk("latency", HIT_VALID, 1'b1);
            if (exp_q.size() == 0) chk("spurious_valid", HIT_VALID, 1'b0);
            else if (HIT_VALID) check_rec(exp_q[0]);
        end
        want_valid = 1'b0;
        pop = IN_READ;
        acc = HIT_VALID && HIT_READY;
        if (pop && fifo.size() > 0) begin
            model_pop(fifo[0], done);
            want_valid = done;
        end
        @(posedge BUS_CLK);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        if (acc) begin
            n_out++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        drive_in();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        pend.delete();
        exp_q.delete();
        m_seq = 0;
        m_id = 0;
        want_valid = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        @(negedge BUS_CLK);
        chk("rst_valid", HIT_VALID, 1'b0);
        chk("rst_fields", {HIT_COL, HIT_ROW, HIT_LE, HIT_TE, HIT_TOT, HIT_NOISE, HIT_MUTE}, 0);
        chk("rst_ts", HIT_TS, 0);
        chk("rst_cnts", {SEQ_ERR_CNT, ID_ERR_CNT}, 0);
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        ENABLE = 1'b1;
        HIT_READY = 1'b1;
        while ((fifo.size() > 0 || HIT_VALID || exp_q.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        tick();
        chk("drain_left", fifo.size() + exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!HIT_VALID && k < budget) begin
            tick();
            k++;
        end
        chk("wait_valid", HIT_VALID, 1'b1);
    endtask

    initial begin
        int base;
        RST = 1'b1;
        ENABLE = 1'b1;
        HIT_READY = 1'b1;
        drive_in();
        do_reset();

        // Clean group with known fields
        HIT_READY = 1'b0;
        fifo.push_back(32'h00A52864);
        fifo.push_back(mk_m(48'h1234, 1'b1, 1'b0));
        fifo.push_back(mk_h(48'h1234));
        drive_in();
        wait_valid(10);
        @(negedge BUS_CLK);
        chk("clean_col", HIT_COL, 6'd5);
        chk("clean_le", HIT_LE, 6'd10);
        chk("clean_te", HIT_TE, 6'd20);
        chk("clean_row", HIT_ROW, 9'd100);
        chk("clean_mute_noise", {HIT_MUTE, HIT_NOISE}, 2'b10);
        chk("clean_ts", HIT_TS, 48'h1234);
        chk("clean_cnts", {SEQ_ERR_CNT, ID_ERR_CNT}, 0);
        @(posedge BUS_CLK);
        #1;
        drain(20);

        // Backpressure with two groups queued
        base = n_out;
        HIT_READY = 1'b0;
        for (int g = 0; g < 2; g++) begin
            fifo.push_back(mk_d(g + 1, 3 * g, 40 + g, 200 + g));
            fifo.push_back(mk_m(48'hABCDE + g, g[0], 1'b1));
            fifo.push_back(mk_h(48'hFEDC_BA98_7654 + g));
        end
        drive_in();
        repeat (13) tick();
        chk("bp_valid_held", HIT_VALID, 1'b1);
        chk("bp_fifo_left", fifo.size(), 3);
        drain(30);
        chk("bp_records", n_out - base, 2);

        // D,D,M,H: one record from the second D
        do_reset();
        base = n_out;
        fifo.push_back(mk_d(1, 2, 3, 4));
        fifo.push_back(mk_d(60, 7, 9, 511));
        fifo.push_back(mk_m(48'h7FFFFF, 1'b0, 1'b1));
        fifo.push_back(mk_h(48'h8000_0000_0000));
        drive_in();
        drain(20);
        chk("ddmh_seq", SEQ_ERR_CNT, 1);
        chk("ddmh_records", n_out - base, 1);

        // M,H alone: no record, two sequence errors
        do_reset();
        base = n_out;
        fifo.push_back(mk_m(48'h1, 1'b0, 1'b0));
        fifo.push_back(mk_h(48'h1));
        drive_in();
        drain(20);
        chk("mh_seq", SEQ_ERR_CNT, 2);
        chk("mh_records", n_out - base, 0);

        // Bad identifier inside a valid group
        do_reset();
        base = n_out;
        fifo.push_back(mk_d(9, 8, 7, 6));
        fifo.push_back({4'hF, mk_d(33, 33, 33, 33)} & 32'hF7FF_FFFF | 32'hF000_0000);
        fifo.push_back(mk_m(48'h55AA55, 1'b1, 1'b1));
        fifo.push_back(mk_h(48'h0123_4567_89AB));
        drive_in();
        drain(20);
        chk("id_err", ID_ERR_CNT, 1);
        chk("id_seq", SEQ_ERR_CNT, 0);
        chk("id_records", n_out - base, 1);

        // Saturation: five stray M words
        do_reset();
        for (int i = 0; i < 5; i++) fifo.push_back(mk_m(48'(i), 1'b0, 1'b0));
        drive_in();
        drain(20);
        chk("sat_seq", SEQ_ERR_CNT, 3);

        // TOT wrap: le=60 te=4
        do_reset();
        HIT_READY = 1'b0;
        fifo.push_back(mk_d(2, 60, 4, 17));
        fifo.push_back(mk_m(48'h0, 1'b0, 1'b0));
        fifo.push_back(mk_h(48'h0));
        drive_in();
        wait_valid(10);
        @(negedge BUS_CLK);
`ifdef MONO_TOT_CALC_EN
        chk("tot_wrap", HIT_TOT, 6'd8);
`else
        chk("tot_off", HIT_TOT, 6'd0);
`endif
        @(posedge BUS_CLK);
        #1;
        drain(20);

        // Reset after a partial group
        do_reset();
        fifo.push_back(mk_d(11, 12, 13, 14));
        fifo.push_back(mk_m(48'h42, 1'b1, 1'b0));
        drive_in();
        repeat (4) tick();
        do_reset();
        base = n_out;
        fifo.push_back(mk_d(21, 22, 23, 24));
        fifo.push_back(mk_m(48'h99, 1'b0, 1'b1));
        fifo.push_back(mk_h(48'h99));
        drive_in();
        drain(20);
        chk("rst_partial_records", n_out - base, 1);
        chk("rst_partial_seq", SEQ_ERR_CNT, 0);

        // Random mixture against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (fifo.size() < 6 && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 9) < 7) begin
                    logic [47:0] ts;
                    ts = {$urandom, $urandom};
                    fifo.push_back(mk_d($urandom_range(0, 63), $urandom_range(0, 63),
                                        $urandom_range(0, 63), $urandom_range(0, 511)));
                    fifo.push_back(mk_m(ts, 1'($urandom), 1'($urandom)));
                    fifo.push_back(mk_h(ts));
                end else begin
                    logic [31:0] w;
                    w = $urandom;
                    if ($urandom_range(0, 3) != 0) w[31:28] = ID;
                    fifo.push_back(w);
                end
                if (fifo.size() == 1 || IN_EMPTY) drive_in();
            end
            ENABLE = ($urandom_range(0, 3) != 0);
            HIT_READY = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
